// File: rtl/dcache_victim_buffer_pkg.sv
// dcache_victim_buffer_pkg: shared defaults and FSM encoding for the dcache victim buffer.
//   VB_LINE_W_DEF   : default cacheline width (8 x 32-bit words)
//   VB_OFFSET_W_DEF : default line-offset width
//   vb_state_e      : one-hot writeback FSM state
package dcache_victim_buffer_pkg;
    localparam int VB_LINE_W_DEF   = 256;
    localparam int VB_OFFSET_W_DEF = 5;
    typedef enum logic [2:0] {
        VB_IDLE  = 3'b001,
        VB_ISSUE = 3'b010,
        VB_WAIT  = 3'b100
    } vb_state_e;
endpackage

// File: rtl/dcache_victim_buffer_vb_match.sv
// vb_match: DEPTH-way line-address comparator, youngest matching entry wins.
//   tags   in  DEPTH*TAG_W  stored line tags, entry i at [i*TAG_W +: TAG_W]
//   valid  in  DEPTH        entry valid bits
//   wr_ptr in  PTR_W        next write slot; the entry just behind it is the youngest
//   tag    in  TAG_W        line tag to look up
//   hit    out 1            some valid entry matches
//   idx    out PTR_W        index of the youngest matching entry
module vb_match #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 27,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH*TAG_W-1:0] tags,
    input  logic [DEPTH-1:0]       valid,
    input  logic [PTR_W-1:0]       wr_ptr,
    input  logic [TAG_W-1:0]       tag,
    output logic                   hit,
    output logic [PTR_W-1:0]       idx
);
    logic [PTR_W-1:0] sel;

    // Scan oldest to youngest so the youngest match is the last to assign.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        sel = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            sel = wr_ptr - PTR_W'(k);
            if (valid[sel] && tags[int'(sel)*TAG_W +: TAG_W] == tag) begin
                hit = 1'b1;
                idx = sel;
            end
        end
    end
endmodule

// File: rtl/dcache_victim_buffer.sv
// dcache_victim_buffer: dirty-line writeback FIFO between the dcache controller and dcache_axi.
//   aclk, aresetn                 clock, asynchronous active-low reset
//   evict_valid/addr/data/ready   one-cycle acceptance of an evicted dirty line
//   lookup_addr/hit/data          combinational refill lookup, youngest copy wins
//   rd_pending_i, axi_idle_i      hold off drain start while a read is outstanding or axi busy
//   ca_wreq_o, wb_addr_o/data_o   single-cycle write request with the head entry
//   axi_wend_i                    write-end from dcache_axi; pops the head
//   empty_o, full_o               occupancy status
module dcache_victim_buffer
    import dcache_victim_buffer_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int LINE_W   = VB_LINE_W_DEF,
    parameter int OFFSET_W = VB_OFFSET_W_DEF
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              evict_valid,
    input  logic [31:0]       evict_addr,
    input  logic [LINE_W-1:0] evict_data,
    output logic              evict_ready,
    input  logic [31:0]       lookup_addr,
    output logic              lookup_hit,
    output logic [LINE_W-1:0] lookup_data,
    input  logic              rd_pending_i,
    input  logic              axi_idle_i,
    output logic              ca_wreq_o,
    output logic [31:0]       wb_addr_o,
    output logic [LINE_W-1:0] wb_data_o,
    input  logic              axi_wend_i,
    output logic              empty_o,
    output logic              full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = 32 - OFFSET_W;

    logic [TAG_W-1:0]       tag_q  [DEPTH];
    logic [LINE_W-1:0]      data_q [DEPTH];
    logic [DEPTH-1:0]       valid_q;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    vb_state_e              state_q;
    logic [DEPTH*TAG_W-1:0] tags_flat;
    logic [PTR_W-1:0]       hit_idx;
    logic                   push, pop;

    assign empty_o     = count_q == '0;
    assign full_o      = count_q == CNT_W'(DEPTH);
    assign evict_ready = !full_o;
    assign push        = evict_valid && evict_ready;
    assign pop         = state_q == VB_WAIT && axi_wend_i;
    assign wb_addr_o   = {tag_q[rd_ptr_q], {OFFSET_W{1'b0}}};
    assign wb_data_o   = data_q[rd_ptr_q];
    assign lookup_data = lookup_hit ? data_q[hit_idx] : '0;

    always_comb begin
        tags_flat = '0;
        for (int i = 0; i < DEPTH; i++)
            tags_flat[i*TAG_W +: TAG_W] = tag_q[i];
    end

    vb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PTR_W(PTR_W)) u_match (
        .tags   (tags_flat),
        .valid  (valid_q),
        .wr_ptr (wr_ptr_q),
        .tag    (lookup_addr[31:OFFSET_W]),
        .hit    (lookup_hit),
        .idx    (hit_idx)
    );

    // Line storage is deliberately left unreset; valid_q qualifies it.
    always_ff @(posedge aclk) begin
        if (push) begin
            tag_q[wr_ptr_q]  <= evict_addr[31:OFFSET_W];
            data_q[wr_ptr_q] <= evict_data;
        end
    end

    // Push and pop never target the same slot: push needs a free slot, pop a filled head.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= VB_IDLE;
            ca_wreq_o <= 1'b0;
        end else begin
            case (state_q)
                VB_IDLE: begin
                    if (!empty_o && axi_idle_i && !rd_pending_i) begin
                        state_q   <= VB_ISSUE;
                        ca_wreq_o <= 1'b1;
                    end
                end
                VB_ISSUE: begin
                    state_q   <= VB_WAIT;
                    ca_wreq_o <= 1'b0;
                end
                VB_WAIT: begin
                    if (axi_wend_i)
                        state_q <= VB_IDLE;
                end
                default: begin
                    state_q   <= VB_IDLE;
                    ca_wreq_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
